// File: rtl/ycbcr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ycbcr_pkg
// Description : Shared types, coefficient table and width helpers for the
//               RGB->YCbCr converter.
// Revision    : 1.0 - initial release
// ============================================================================
package ycbcr_pkg;

    // Matrix selection; code 2'b11 aliases BT.601 full range
    typedef enum logic [1:0] {
        MODE_601F     = 2'b00,
        MODE_601S     = 2'b01,
        MODE_709F     = 2'b10,
        MODE_601F_ALT = 2'b11
    } mode_e;

    // 4:2:2 chroma phase within a line
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_e;

    localparam int COEF_W = 9;
    typedef logic signed [COEF_W-1:0] coef_t;

    // Q8 coefficients for one matrix: rows Y, Cb, Cr; columns R, G, B
    typedef struct packed {
        coef_t yr;  coef_t yg;  coef_t yb;
        coef_t cbr; coef_t cbg; coef_t cbb;
        coef_t crr; coef_t crg; coef_t crb;
    } coef_set_t;

    localparam coef_set_t C_601F = '{ 9'sd77,  9'sd150,  9'sd29,
                                     -9'sd43, -9'sd85,   9'sd128,
                                      9'sd128, -9'sd107, -9'sd21 };
    localparam coef_set_t C_601S = '{ 9'sd66,  9'sd129,  9'sd25,
                                     -9'sd38, -9'sd74,   9'sd112,
                                      9'sd112, -9'sd94,  -9'sd18 };
    localparam coef_set_t C_709F = '{ 9'sd54,  9'sd183,  9'sd19,
                                     -9'sd29, -9'sd99,   9'sd128,
                                      9'sd128, -9'sd116, -9'sd12 };

    // Indexed by mode code; entry 3 mirrors BT.601 full range
    localparam coef_set_t [3:0] COEF_TAB = {C_601F, C_709F, C_601S, C_601F};

    // Signed product width: Q8 coefficient times zero-extended pixel
    function automatic int prod_w(input int data_w);
        return data_w + 10;
    endfunction

    // Accumulator width: three products plus offset and rounding
    function automatic int sum_w(input int data_w);
        return data_w + 12;
    endfunction

    // Video sync flags carried alongside each pixel
    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

endpackage
`default_nettype wire

// File: rtl/image_rgb_ycbcr_cvt_if.sv
`default_nettype none
// ============================================================================
// Interface   : image_rgb_ycbcr_cvt_if
// Description : Configuration, input video and output video bus of the
//               RGB->YCbCr converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface image_rgb_ycbcr_cvt_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        cfg_mode;
    logic              cfg_422;
    logic              per_frame_vsync;
    logic              per_frame_href;
    logic              per_frame_clken;
    logic [DATA_W-1:0] per_img_red;
    logic [DATA_W-1:0] per_img_green;
    logic [DATA_W-1:0] per_img_blue;
    logic              post_frame_vsync;
    logic              post_frame_href;
    logic              post_frame_clken;
    logic [DATA_W-1:0] post_img_Y;
    logic [DATA_W-1:0] post_img_Cb;
    logic [DATA_W-1:0] post_img_Cr;

    modport master (
        output cfg_mode, cfg_422,
        output per_frame_vsync, per_frame_href, per_frame_clken,
        output per_img_red, per_img_green, per_img_blue,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_Y, post_img_Cb, post_img_Cr
    );

    modport slave (
        input  cfg_mode, cfg_422,
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        input  per_img_red, per_img_green, per_img_blue,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_Y, post_img_Cb, post_img_Cr
    );
endinterface
`default_nettype wire

// File: rtl/ycbcr_dot3.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr_dot3
// Description : One output channel: three Q8 multiplies (S1), offset and
//               rounding sum (S2), shift and clamp to the pixel range (S3).
// Revision    : 1.0 - initial release
// ============================================================================
module ycbcr_dot3
    import ycbcr_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [DATA_W-1:0] pix_r,
    input  wire logic [DATA_W-1:0] pix_g,
    input  wire logic [DATA_W-1:0] pix_b,
    input  wire coef_t             coef_r,
    input  wire coef_t             coef_g,
    input  wire coef_t             coef_b,
    input  wire logic [DATA_W-1:0] ofs,
    output logic      [DATA_W-1:0] res
);
    localparam int PROD_W = prod_w(DATA_W);
    localparam int SUM_W  = sum_w(DATA_W);
    localparam logic signed [SUM_W-1:0] C_ROUND = SUM_W'(128);

    logic signed [PROD_W-1:0] prod_d [3];
    logic signed [PROD_W-1:0] prod_q [3];
    logic signed [SUM_W-1:0]  sum_d, sum_q, sum_shr;
    logic        [DATA_W-1:0] clamp_d, clamp_q;

    // Pixel is unsigned, so it is zero-extended before the signed multiply
    function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_W-1:0] pix,
                                                     input coef_t c);
        logic signed [PROD_W-1:0] pix_s;
        pix_s = $signed(PROD_W'(pix));
        return pix_s * PROD_W'(c);
    endfunction

    // S1 products, S2 offset/rounding sum, S3 arithmetic shift and clamp
    always_comb begin
        prod_d[0] = mul(pix_r, coef_r);
        prod_d[1] = mul(pix_g, coef_g);
        prod_d[2] = mul(pix_b, coef_b);
        sum_d     = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2])
                  + $signed(SUM_W'({ofs, 8'h00})) + C_ROUND;
        sum_shr   = sum_q >>> 8;
        if (sum_shr[SUM_W-1]) begin
            clamp_d = '0;
        end else if (|sum_shr[SUM_W-2:DATA_W]) begin
            clamp_d = '1;
        end else begin
            clamp_d = sum_shr[DATA_W-1:0];
        end
    end

    // Pipeline registers for S1..S3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) prod_q[i] <= '0;
            sum_q   <= '0;
            clamp_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) prod_q[i] <= prod_d[i];
            sum_q   <= sum_d;
            clamp_q <= clamp_d;
        end
    end

    assign res = clamp_q;

endmodule
`default_nettype wire

// File: rtl/image_rgb_ycbcr_cvt.sv
`default_nettype none
// ============================================================================
// Module      : image_rgb_ycbcr_cvt
// Description : RGB->YCbCr converter, 4-clock fixed latency, frame-latched
//               matrix selection and optional 4:2:2 co-sited chroma.
// Revision    : 1.0 - initial release
// ============================================================================
module image_rgb_ycbcr_cvt
    import ycbcr_pkg::*;
#(
    parameter int         DATA_W       = 8,
    parameter logic [1:0] DEFAULT_MODE = 2'b00,
    parameter logic       DEFAULT_422  = 1'b0
) (
    input wire logic              clk,
    input wire logic              rst,
    image_rgb_ycbcr_cvt_if.slave  bus
);
    localparam logic [DATA_W-1:0] C_OFS_Y_STUDIO = DATA_W'(16 << (DATA_W - 8));
    localparam logic [DATA_W-1:0] C_OFS_C        = DATA_W'(128 << (DATA_W - 8));

    logic              vsync_prev_d, vsync_prev_q;
    logic [1:0]        mode_d, mode_q;
    logic              fmt422_d, fmt422_q;
    logic              studio_s1_d, studio_s1_q;
    sync_t             sync_d [3];
    sync_t             sync_q [3];
    logic              f422_d [3];
    logic              f422_q [3];
    parity_e           parity_d, parity_q;
    logic [DATA_W-1:0] cr_hold_d, cr_hold_q;
    sync_t             post_sync_d, post_sync_q;
    logic [DATA_W-1:0] y_d, y_q, cb_d, cb_q, cr_d, cr_q;

    coef_set_t         coef_sel;
    logic [DATA_W-1:0] ofs_y;
    logic [DATA_W-1:0] y_s3, cb_s3, cr_s3;

    // Coefficients follow the active cfg into S1; the studio offset rides one stage behind
    assign coef_sel = COEF_TAB[mode_q];
    assign ofs_y    = studio_s1_q ? C_OFS_Y_STUDIO : '0;

    ycbcr_dot3 #(.DATA_W(DATA_W)) u_y (
        .clk(clk), .rst(rst),
        .pix_r(bus.per_img_red), .pix_g(bus.per_img_green), .pix_b(bus.per_img_blue),
        .coef_r(coef_sel.yr), .coef_g(coef_sel.yg), .coef_b(coef_sel.yb),
        .ofs(ofs_y), .res(y_s3)
    );

    ycbcr_dot3 #(.DATA_W(DATA_W)) u_cb (
        .clk(clk), .rst(rst),
        .pix_r(bus.per_img_red), .pix_g(bus.per_img_green), .pix_b(bus.per_img_blue),
        .coef_r(coef_sel.cbr), .coef_g(coef_sel.cbg), .coef_b(coef_sel.cbb),
        .ofs(C_OFS_C), .res(cb_s3)
    );

    ycbcr_dot3 #(.DATA_W(DATA_W)) u_cr (
        .clk(clk), .rst(rst),
        .pix_r(bus.per_img_red), .pix_g(bus.per_img_green), .pix_b(bus.per_img_blue),
        .coef_r(coef_sel.crr), .coef_g(coef_sel.crg), .coef_b(coef_sel.crb),
        .ofs(C_OFS_C), .res(cr_s3)
    );

    // Cfg latch on vsync rise, and sync/format flags travelling with the pixel
    always_comb begin
        vsync_prev_d = bus.per_frame_vsync;
        mode_d       = mode_q;
        fmt422_d     = fmt422_q;
        if (bus.per_frame_vsync && !vsync_prev_q) begin
            mode_d   = bus.cfg_mode;
            fmt422_d = bus.cfg_422;
        end
        studio_s1_d = (mode_q == MODE_601S);
        sync_d[0]   = '{vsync: bus.per_frame_vsync, href: bus.per_frame_href,
                        clken: bus.per_frame_clken};
        sync_d[1]   = sync_q[0];
        sync_d[2]   = sync_q[1];
        f422_d[0]   = fmt422_q;
        f422_d[1]   = f422_q[0];
        f422_d[2]   = f422_q[1];
    end

    // Parity FSM: every line starts even, toggles on each valid S3 pixel
    always_comb begin
        parity_d = parity_q;
        if (!sync_q[2].href) begin
            parity_d = PAR_EVEN;
        end else if (sync_q[2].clken) begin
            parity_d = (parity_q == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
        end
    end

    // S4: chroma mux and blanking outside active lines
    always_comb begin
        cr_hold_d   = cr_hold_q;
        post_sync_d = sync_q[2];
        y_d         = '0;
        cb_d        = '0;
        cr_d        = '0;
        if (sync_q[2].href) begin
            y_d = y_s3;
            if (f422_q[2]) begin
                if (parity_q == PAR_EVEN) begin
                    cb_d = cb_s3;
                    if (sync_q[2].clken) cr_hold_d = cr_s3;
                end else begin
                    cb_d = cr_hold_q;
                end
            end else begin
                cb_d = cb_s3;
                cr_d = cr_s3;
            end
        end
    end

    // State registers; reset restores the default cfg and flushes the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            mode_q       <= DEFAULT_MODE;
            fmt422_q     <= DEFAULT_422;
            studio_s1_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= '0;
                f422_q[i] <= 1'b0;
            end
            parity_q    <= PAR_EVEN;
            cr_hold_q   <= '0;
            post_sync_q <= '0;
            y_q         <= '0;
            cb_q        <= '0;
            cr_q        <= '0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            mode_q       <= mode_d;
            fmt422_q     <= fmt422_d;
            studio_s1_q  <= studio_s1_d;
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= sync_d[i];
                f422_q[i] <= f422_d[i];
            end
            parity_q    <= parity_d;
            cr_hold_q   <= cr_hold_d;
            post_sync_q <= post_sync_d;
            y_q         <= y_d;
            cb_q        <= cb_d;
            cr_q        <= cr_d;
        end
    end

    assign bus.post_frame_vsync = post_sync_q.vsync;
    assign bus.post_frame_href  = post_sync_q.href;
    assign bus.post_frame_clken = post_sync_q.clken;
    assign bus.post_img_Y       = y_q;
    assign bus.post_img_Cb      = cb_q;
    assign bus.post_img_Cr      = cr_q;

endmodule
`default_nettype wire

// File: tb/tb_image_rgb_ycbcr_cvt.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_rgb_ycbcr_cvt
// Description : Directed bench for the RGB->YCbCr converter (8- and 10-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_rgb_ycbcr_cvt;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    typedef struct packed {
        logic       vs;
        logic       hr;
        logic       ce;
        logic       ck;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } exp_t;

    exp_t e [4];

    image_rgb_ycbcr_cvt_if #(.DATA_W(8))  b8 ();
    image_rgb_ycbcr_cvt_if #(.DATA_W(10)) b10 ();

    image_rgb_ycbcr_cvt #(.DATA_W(8), .DEFAULT_MODE(2'b00), .DEFAULT_422(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .bus(b8)
    );

    image_rgb_ycbcr_cvt #(.DATA_W(10), .DEFAULT_MODE(2'b00), .DEFAULT_422(1'b0)) u_dut10 (
        .clk(clk), .rst(rst), .bus(b10)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle on the 8-bit DUT and check the output of the input 4 clk earlier
    task automatic px(input logic vs, input logic hr, input logic ce,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [7:0] ey, input logic [7:0] ecb, input logic [7:0] ecr,
                      input logic ck);
        b8.per_frame_vsync = vs;
        b8.per_frame_href  = hr;
        b8.per_frame_clken = ce;
        b8.per_img_red     = r;
        b8.per_img_green   = g;
        b8.per_img_blue    = b;
        e[3] = e[2];
        e[2] = e[1];
        e[1] = e[0];
        e[0] = '{vs, hr, ce, ck, ey, ecb, ecr};
        tick();
        chk("post_vsync", b8.post_frame_vsync, e[3].vs);
        chk("post_href",  b8.post_frame_href,  e[3].hr);
        chk("post_clken", b8.post_frame_clken, e[3].ce);
        if (!e[3].hr) begin
            chk("blank_Y",  b8.post_img_Y,  0);
            chk("blank_Cb", b8.post_img_Cb, 0);
            chk("blank_Cr", b8.post_img_Cr, 0);
        end else if (e[3].ck) begin
            chk("Y",  b8.post_img_Y,  e[3].y);
            chk("Cb", b8.post_img_Cb, e[3].cb);
            chk("Cr", b8.post_img_Cr, e[3].cr);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Single pixel through the 10-bit DUT, checked exactly 4 clk later
    task automatic d10_pix(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                           input logic [9:0] ey, input logic [9:0] ecb, input logic [9:0] ecr);
        b10.per_frame_href  = 1'b1;
        b10.per_frame_clken = 1'b1;
        b10.per_img_red     = r;
        b10.per_img_green   = g;
        b10.per_img_blue    = b;
        tick();
        b10.per_frame_href  = 1'b0;
        b10.per_frame_clken = 1'b0;
        b10.per_img_red     = '0;
        b10.per_img_green   = '0;
        b10.per_img_blue    = '0;
        tick();
        tick();
        chk("d10_clken_early", b10.post_frame_clken, 0);
        tick();
        chk("d10_clken", b10.post_frame_clken, 1);
        chk("d10_Y",     b10.post_img_Y,  ey);
        chk("d10_Cb",    b10.post_img_Cb, ecb);
        chk("d10_Cr",    b10.post_img_Cr, ecr);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vsync"}, b8.post_frame_vsync, 0);
        chk({tag, "_href"},  b8.post_frame_href,  0);
        chk({tag, "_clken"}, b8.post_frame_clken, 0);
        chk({tag, "_Y"},     b8.post_img_Y,  0);
        chk({tag, "_Cb"},    b8.post_img_Cb, 0);
        chk({tag, "_Cr"},    b8.post_img_Cr, 0);
        chk({tag, "_d10_href"}, b10.post_frame_href, 0);
        chk({tag, "_d10_Y"},    b10.post_img_Y, 0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) e[i] = '0;
        rst = 1'b1;
        b8.cfg_mode = 2'b00;  b8.cfg_422 = 1'b0;
        b8.per_frame_vsync = 0; b8.per_frame_href = 0; b8.per_frame_clken = 0;
        b8.per_img_red = 0; b8.per_img_green = 0; b8.per_img_blue = 0;
        b10.cfg_mode = 2'b00; b10.cfg_422 = 1'b0;
        b10.per_frame_vsync = 0; b10.per_frame_href = 0; b10.per_frame_clken = 0;
        b10.per_img_red = 0; b10.per_img_green = 0; b10.per_img_blue = 0;

        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Default matrix holds until a vsync rise, even with a different cfg requested
        b8.cfg_mode = 2'b01;
        px(0, 1, 1, 255, 255, 255, 255, 128, 128, 1);
        px(0, 1, 1, 255,   0,   0,  77,  85, 255, 1);
        px(0, 1, 1,   0,   0, 255,  29, 255, 107, 1);
        idle(4);

        // BT.601 studio frame
        px(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        px(0, 1, 1,   0,   0,   0,  16, 128, 128, 1);
        px(0, 1, 1, 255, 255, 255, 235, 128, 128, 1);
        idle(4);

        // Mode change mid-frame only takes effect at the next vsync rise
        b8.cfg_mode = 2'b00;
        px(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        px(0, 1, 1, 255, 0, 0, 77, 85, 255, 1);
        b8.cfg_mode = 2'b10;
        px(0, 1, 1, 255, 0, 0, 77, 85, 255, 1);
        px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        px(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        px(0, 1, 1, 255, 0, 0, 54, 99, 255, 1);
        idle(2);
        b8.cfg_mode = 2'b11;
        px(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        px(0, 1, 1, 255, 0, 0, 77, 85, 255, 1);
        idle(4);

        // 4:2:2 line of 5 pixels with clken gaps, then a new line restarting on Cb
        b8.cfg_mode = 2'b00;
        b8.cfg_422  = 1'b1;
        px(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        px(0, 1, 1, 255, 255,   0, 226,   1, 0, 1);
        px(0, 1, 0,   0,   0,   0,   0,   0, 0, 0);
        px(0, 1, 1,   0, 255,   0, 149, 149, 0, 1);
        px(0, 1, 0,   0,   0,   0,   0,   0, 0, 0);
        px(0, 1, 1,   0,   0, 255,  29, 255, 0, 1);
        px(0, 1, 1, 255, 255, 255, 255, 107, 0, 1);
        px(0, 1, 0,   0,   0,   0,   0,   0, 0, 0);
        px(0, 1, 0,   0,   0,   0,   0,   0, 0, 0);
        px(0, 1, 1,   0,   0,   0,   0, 128, 0, 1);
        px(0, 0, 0,   0,   0,   0,   0,   0, 0, 0);
        px(0, 0, 0,   0,   0,   0,   0,   0, 0, 0);
        px(0, 1, 1, 255,   0,   0,  77,  85, 0, 1);
        px(0, 1, 1, 255,   0,   0,  77, 255, 0, 1);
        px(0, 0, 0,   0,   0,   0,   0,   0, 0, 0);

        // Mid-line reset: outputs drop to 0 immediately, cfg returns to defaults
        b8.cfg_mode = 2'b10;
        for (int i = 0; i < 5; i++) px(0, 1, 1, 255, 255, 255, 255, 128, 0, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) e[i] = '0;
        px(0, 1, 1, 255, 255, 255, 255, 128, 128, 1);
        px(0, 1, 1, 255,   0,   0,  77,  85, 255, 1);
        idle(4);
        px(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        px(0, 1, 1, 255,   0,   0,  54,  99, 0, 1);
        idle(4);

        // 10-bit instance: white and a clamping red
        d10_pix(10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd512, 10'd512);
        d10_pix(10'd1023, 10'd0,    10'd0,    10'd308,  10'd340, 10'd1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
